// File: rtl/axis_rr_arbiter.sv
// Purpose : round-robin, packet-locked arbiter sharing one AXI-Stream sink among N_SRC sources.
// Latency : one-cycle arbitration bubble (IDLE -> BUSY), then zero-latency combinational pass-through.
// Backpressure: m_tready is steered to the granted source only; other sources see s_tready=0.
//
// Ports: clk/resetn (async active-low); s_tdata/s_tvalid/s_tlast/s_tready per-source stream
// (port i at s_tdata[i*DATA_W +: DATA_W]); m_tdata/m_tvalid/m_tlast/m_tid/m_tready sink stream;
// busy is high while a grant is held.
module axis_rr_arbiter #(
    parameter int N_SRC     = 4,
    parameter int DATA_W    = 16,
    parameter int MAX_BEATS = 0,
    parameter int ID_W      = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [N_SRC*DATA_W-1:0]   s_tdata,
    input  logic [N_SRC-1:0]          s_tvalid,
    input  logic [N_SRC-1:0]          s_tlast,
    output logic [N_SRC-1:0]          s_tready,
    output logic [DATA_W-1:0]         m_tdata,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    output logic [ID_W-1:0]           m_tid,
    input  logic                      m_tready,
    output logic                      busy
);

    localparam int GW    = $clog2(N_SRC);
    localparam int CNT_W = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             xfer;
    logic             cap_hit;
    logic             found;
    int               idx;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        s_tready   = '0;
        m_tdata    = '0;
        m_tvalid   = 1'b0;
        m_tlast    = 1'b0;
        m_tid      = '0;
        busy       = 1'b0;
        xfer       = 1'b0;
        cap_hit    = 1'b0;
        found      = 1'b0;
        idx        = 0;

        case (state_q)
            IDLE: begin
                // Scan starting at rr_ptr and wrapping; first requester found wins.
                for (int k = 0; k < N_SRC; k++) begin
                    idx = (int'(rr_ptr_q) + k) % N_SRC;
                    if (!found && s_tvalid[idx]) begin
                        found   = 1'b1;
                        grant_d = GW'(idx);
                    end
                end
                if (found) begin
                    state_d    = BUSY;
                    beat_cnt_d = '0;
                end
            end
            BUSY: begin
                m_tdata           = s_tdata[int'(grant_q)*DATA_W +: DATA_W];
                m_tvalid          = s_tvalid[grant_q];
                m_tlast           = s_tlast[grant_q];
                s_tready[grant_q] = m_tready;
                m_tid             = ID_W'(grant_q);
                busy              = 1'b1;
                xfer              = m_tvalid && m_tready;
                if (MAX_BEATS != 0) begin
                    cap_hit = (32'(beat_cnt_q) + 32'd1) == 32'(MAX_BEATS);
                end
                if (xfer) begin
                    if (beat_cnt_q != '1) begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                    // tlast and cap on the same beat collapse into one release.
                    if (m_tlast || cap_hit) begin
                        state_d  = IDLE;
                        rr_ptr_d = (int'(grant_q) == N_SRC - 1) ? '0 : grant_q + GW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Purpose : self-checking bench for axis_rr_arbiter (4 sources, 16-bit data, 3-beat cap).
// Latency : checks the arbitration bubble after every packet end and the grant order.
// Backpressure: drives fixed or random m_tready and random source valid gaps.
module tb_axis_rr_arbiter;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [63:0] s_tdata;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tlast;
    logic [3:0]  s_tready;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [1:0]  m_tid;
    logic        m_tready;
    logic        busy;

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t send_q[4][$];
    beat_t exp_q[4][$];
    int    tid_q[$];
    bit    tid_chk   = 1'b0;
    bit    rand_mode = 1'b0;

    always #5 clk = ~clk;

    axis_rr_arbiter #(.N_SRC(4), .DATA_W(16), .MAX_BEATS(3), .ID_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tid(m_tid),
        .m_tready(m_tready), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_beat(input int src, input logic [15:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        send_q[src].push_back(b);
        exp_q[src].push_back(b);
    endtask

    task automatic load_pkt(input int src, input int len, input int base);
        for (int b = 0; b < len; b++) push_beat(src, 16'(base + b), b == len - 1);
    endtask

    function automatic int pending();
        int n = tid_chk ? tid_q.size() : 0;
        for (int i = 0; i < 4; i++) n += send_q[i].size() + exp_q[i].size();
        return n;
    endfunction

    task automatic wait_drain(input int budget);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n >= budget, 0);
        repeat (2) @(negedge clk);
    endtask

    // Source drivers + sink monitor: sample at negedge, advance after posedge.
    initial begin
        logic [3:0] fire;
        bit         after_last;
        beat_t      e;
        int         src;
        after_last = 1'b0;
        m_tready   = 1'b1;
        s_tvalid   = '0;
        s_tlast    = '0;
        s_tdata    = '0;
        forever begin
            @(negedge clk);
            fire = s_tvalid & s_tready;
            chk("onehot0", $countones(s_tready) <= 1, 1);
            if (resetn && after_last) chk("bubble", {m_tvalid, busy}, 2'b00);
            after_last = 1'b0;
            if (m_tvalid && m_tready) begin
                src = int'(m_tid);
                if (exp_q[src].size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    e = exp_q[src].pop_front();
                    chk("tdata", m_tdata, e.d);
                    chk("tlast", m_tlast, e.l);
                end
                if (tid_chk) begin
                    if (tid_q.size() == 0) chk("tid_extra", 1, 0);
                    else chk("tid", m_tid, tid_q.pop_front());
                end
                after_last = m_tlast;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (fire[i] && send_q[i].size() != 0) void'(send_q[i].pop_front());
                if (send_q[i].size() != 0) begin
                    s_tvalid[i]          = !rand_mode || ($urandom % 4 != 0);
                    s_tdata[i*16 +: 16]  = send_q[i][0].d;
                    s_tlast[i]           = send_q[i][0].l;
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tlast[i]  = 1'b0;
                end
            end
            m_tready = rand_mode ? 1'($urandom & 1) : 1'b1;
        end
    end

    initial begin
        resetn = 1'b0;
        // Reset with all sources requesting; then 2-beat packets on all ports.
        for (int i = 0; i < 4; i++) load_pkt(i, 2, 16'h100 * (i + 1));
        load_pkt(0, 2, 16'h0a00);
        repeat (3) @(negedge clk);
        chk("rst_svalid", s_tvalid, 4'hF);
        chk("rst_tready", s_tready, 0);
        chk("rst_mvalid", m_tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mtlast", m_tlast, 0);
        chk("rst_mtdata", m_tdata, 0);
        chk("rst_mtid", m_tid, 0);
        tid_chk = 1'b1;
        tid_q = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        resetn = 1'b1;
        wait_drain(200);

        // Single source on port 2, then search resumes at port 3.
        push_beat(2, 16'd5555, 1'b0);
        push_beat(2, 16'd7, 1'b1);
        tid_q.push_back(2);
        tid_q.push_back(2);
        wait_drain(100);
        load_pkt(0, 1, 16'h0c00);
        load_pkt(3, 1, 16'h3c00);
        tid_q.push_back(3);
        tid_q.push_back(0);
        wait_drain(100);

        // Burst cap of 3 splits port 1's 5-beat packet around port 3.
        load_pkt(1, 5, 16'h1d00);
        load_pkt(3, 2, 16'h3d00);
        tid_q = '{1, 1, 1, 3, 3, 1, 1};
        wait_drain(100);

        // Random sink ready and source gaps on 3 sources.
        tid_chk   = 1'b0;
        rand_mode = 1'b1;
        for (int p = 0; p < 40; p++) begin
            for (int s = 0; s < 3; s++) load_pkt(s, 1 + $urandom_range(4), $urandom_range(16'hfff0));
        end
        wait_drain(20000);
        rand_mode = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a packet on port 1.
        load_pkt(1, 4, 16'h1e00);
        begin
            int n = 0;
            while (send_q[1].size() > 2 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("mid_pkt_timeout", n >= 50, 0);
        end
        chk("mid_pkt_mvalid", m_tvalid, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_mvalid", m_tvalid, 0);
        chk("mid_rst_tready", s_tready, 0);
        chk("mid_rst_busy", busy, 0);
        send_q[1].delete();
        exp_q[1].delete();
        tid_q.delete();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        tid_chk = 1'b1;
        for (int i = 0; i < 4; i++) load_pkt(i, 1, 16'h0f00 + i);
        tid_q = '{0, 1, 2, 3};
        wait_drain(100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
